// File: rtl/vga_layer_compositor.sv
// VGA timing generator with N_LAYERS fixed-priority rectangular sprites over a background.
// Layer parameters are shadowed at the frame wrap, so updates never tear mid-frame.
module vga_layer_compositor #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int N_LAYERS = 4,
  parameter int CW       = 10
) (
  input  logic                   clk50M,
  input  logic                   reset,
  input  logic [N_LAYERS-1:0]    layer_en,
  input  logic [N_LAYERS*CW-1:0] layer_x,
  input  logic [N_LAYERS*CW-1:0] layer_y,
  input  logic [N_LAYERS*CW-1:0] layer_w,
  input  logic [N_LAYERS*CW-1:0] layer_h,
  input  logic [N_LAYERS*8-1:0]  layer_rgb,
  input  logic [7:0]             bg_rgb,
  output logic [2:0]             red,
  output logic [2:0]             green,
  output logic [1:0]             blue,
  output logic                   HS,
  output logic                   VS,
  output logic                   endofframe
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  // Box test on one axis; the offset is only meaningful once p >= org, so it never wraps.
  function automatic logic axis_hit(input logic [CW-1:0] p, input logic [CW-1:0] org,
                                    input logic [CW-1:0] len);
    logic [CW:0] d;
    d = {1'b0, p} - {1'b0, org};
    return (p >= org) && (d < {1'b0, len});
  endfunction

  function automatic logic [7:0] pick_rgb(input logic [N_LAYERS-1:0] hit,
                                          input logic [N_LAYERS*8-1:0] rgb,
                                          input logic [7:0] bg);
    logic [7:0] c;
    c = bg;
    for (int i = N_LAYERS - 1; i >= 0; i--)
      if (hit[i]) c = rgb[i*8 +: 8];
    return c;
  endfunction

  logic          pe_q;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          line_end, frame_end, eof_d, eof_q;

  assign line_end  = (hcount_q == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (vcount_q == VW'(V_TOTAL - 1));
  assign eof_d     = pe_q && line_end && (vcount_q == VW'(V_END - 1));

  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (line_end) begin
      hcount_d = '0;
      vcount_d = frame_end ? '0 : vcount_q + VW'(1);
    end
  end

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      pe_q     <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      eof_q    <= 1'b0;
    end else begin
      pe_q  <= ~pe_q;
      eof_q <= eof_d;
      if (pe_q) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
      end
    end
  end

  logic [N_LAYERS-1:0]    sh_en_q;
  logic [N_LAYERS*CW-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
  logic [N_LAYERS*8-1:0]  sh_rgb_q;
  logic [7:0]             sh_bg_q;

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      sh_en_q  <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_w_q   <= '0;
      sh_h_q   <= '0;
      sh_rgb_q <= '0;
      sh_bg_q  <= '0;
    end else if (pe_q && frame_end) begin
      sh_en_q  <= layer_en;
      sh_x_q   <= layer_x;
      sh_y_q   <= layer_y;
      sh_w_q   <= layer_w;
      sh_h_q   <= layer_h;
      sh_rgb_q <= layer_rgb;
      sh_bg_q  <= bg_rgb;
    end
  end

  // ---- stage 0: raw timing and screen coordinates from the counters ----
  logic          hs_p0, vs_p0, vld_p0;
  logic [CW-1:0] x_p0, y_p0;

  assign hs_p0  = (hcount_q < HW'(H_SYNC));
  assign vs_p0  = (vcount_q < VW'(V_SYNC));
  assign vld_p0 = (hcount_q >= HW'(H_START)) && (hcount_q < HW'(H_END)) &&
                  (vcount_q >= VW'(V_START)) && (vcount_q < VW'(V_END));
  assign x_p0   = CW'(hcount_q - HW'(H_START));
  assign y_p0   = CW'(vcount_q - VW'(V_START));

  // ---- stage 1: per-layer hit vector ----
  logic [N_LAYERS-1:0] hit_p1_d, hit_p1_q;
  logic                vld_p1_q, hs_p1_q, vs_p1_q;

  always_comb begin
    hit_p1_d = '0;
    for (int i = 0; i < N_LAYERS; i++)
      hit_p1_d[i] = sh_en_q[i] &&
                    axis_hit(x_p0, sh_x_q[i*CW +: CW], sh_w_q[i*CW +: CW]) &&
                    axis_hit(y_p0, sh_y_q[i*CW +: CW], sh_h_q[i*CW +: CW]);
  end

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      hit_p1_q <= '0;
      vld_p1_q <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
    end else if (pe_q) begin
      hit_p1_q <= hit_p1_d;
      vld_p1_q <= vld_p0;
      hs_p1_q  <= hs_p0;
      vs_p1_q  <= vs_p0;
    end
  end

  // ---- stage 2: priority colour select and registered pins ----
  logic [7:0] rgb_p2_d, rgb_p2_q;
  logic       hs_n_p2_q, vs_n_p2_q;

  assign rgb_p2_d = vld_p1_q ? pick_rgb(hit_p1_q, sh_rgb_q, sh_bg_q) : 8'h00;

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      rgb_p2_q  <= 8'h00;
      hs_n_p2_q <= 1'b1;
      vs_n_p2_q <= 1'b1;
    end else if (pe_q) begin
      rgb_p2_q  <= rgb_p2_d;
      hs_n_p2_q <= ~hs_p1_q;
      vs_n_p2_q <= ~vs_p1_q;
    end
  end

  assign red        = rgb_p2_q[7:5];
  assign green      = rgb_p2_q[4:2];
  assign blue       = rgb_p2_q[1:0];
  assign HS         = hs_n_p2_q;
  assign VS         = vs_n_p2_q;
  assign endofframe = eof_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench: a frame/pixel model predicts every pin value per clk50M edge
// from tick numbers and per-frame shadow snapshots; a monitor compares on the falling edge.
module tb_vga_layer_compositor;

  localparam int T_HS = 3, T_HB = 2, T_HA = 16, T_HF = 2;
  localparam int T_VS = 2, T_VB = 2, T_VA = 12, T_VF = 2;
  localparam int NL = 4, CWB = 10;
  localparam int HT = T_HS + T_HB + T_HA + T_HF;
  localparam int VT = T_VS + T_VB + T_VA + T_VF;
  localparam int FT = HT * VT;
  localparam int HSTART = T_HS + T_HB;
  localparam int VSTART = T_VS + T_VB;
  localparam int MAXF = 64;

  logic              clk50M = 1'b0;
  logic              reset  = 1'b0;
  logic [NL-1:0]     layer_en;
  logic [NL*CWB-1:0] layer_x, layer_y, layer_w, layer_h;
  logic [NL*8-1:0]   layer_rgb;
  logic [7:0]        bg_rgb;
  logic [2:0]        red, green;
  logic [1:0]        blue;
  logic              HS, VS, endofframe;

  vga_layer_compositor #(
    .H_SYNC(T_HS), .H_BP(T_HB), .H_ACTIVE(T_HA), .H_FP(T_HF),
    .V_SYNC(T_VS), .V_BP(T_VB), .V_ACTIVE(T_VA), .V_FP(T_VF),
    .N_LAYERS(NL), .CW(CWB)
  ) dut (
    .clk50M(clk50M), .reset(reset),
    .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
    .layer_w(layer_w), .layer_h(layer_h), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .red(red), .green(green), .blue(blue), .HS(HS), .VS(VS), .endofframe(endofframe)
  );

  always #10 clk50M = ~clk50M;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs_n;
    logic       vs_n;
    logic       eof;
  } pins_t;

  localparam pins_t RESET_PINS = '{rgb: 8'h00, hs_n: 1'b1, vs_n: 1'b1, eof: 1'b0};

  pins_t exp_q[$];
  pins_t last_pins = RESET_PINS;
  pins_t nxt;
  int    edge_cnt = 0;
  int    tick = 0;
  int    checks = 0;
  int    failures = 0;

  // Per-frame snapshot of what the game logic presented at the end of the previous frame.
  logic [NL-1:0]     sh_en [MAXF];
  logic [NL*CWB-1:0] sh_x  [MAXF];
  logic [NL*CWB-1:0] sh_y  [MAXF];
  logic [NL*CWB-1:0] sh_w  [MAXF];
  logic [NL*CWB-1:0] sh_h  [MAXF];
  logic [NL*8-1:0]   sh_rgb[MAXF];
  logic [7:0]        sh_bg [MAXF];

  function automatic pins_t expect_pixel(input int j);
    pins_t r;
    int hc, vc, f, x, y, lx, ly, lw, lh;
    bit found;
    hc = j % HT;
    vc = (j / HT) % VT;
    f  = j / FT;
    if (f >= MAXF) f = MAXF - 1;
    r.eof  = 1'b0;
    r.hs_n = !(hc < T_HS);
    r.vs_n = !(vc < T_VS);
    r.rgb  = 8'h00;
    if (hc >= HSTART && hc < HSTART + T_HA && vc >= VSTART && vc < VSTART + T_VA) begin
      x = hc - HSTART;
      y = vc - VSTART;
      r.rgb = sh_bg[f];
      found = 1'b0;
      for (int i = 0; i < NL; i++) begin
        lx = int'(sh_x[f][i*CWB +: CWB]);
        ly = int'(sh_y[f][i*CWB +: CWB]);
        lw = int'(sh_w[f][i*CWB +: CWB]);
        lh = int'(sh_h[f][i*CWB +: CWB]);
        if (!found && sh_en[f][i] && x >= lx && x < lx + lw && y >= ly && y < ly + lh) begin
          r.rgb = sh_rgb[f][i*8 +: 8];
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic is_eof_state(input int j);
    return ((j % HT) == HT - 1) && (((j / HT) % VT) == VSTART + T_VA - 1);
  endfunction

  // Model: one expected pin set per clk50M edge; pixel ticks fall on even edges after release.
  initial forever begin
    @(posedge clk50M or negedge reset);
    if (!reset) begin
      edge_cnt  = 0;
      tick      = 0;
      last_pins = RESET_PINS;
      exp_q.delete();
      sh_en[0] = '0; sh_x[0] = '0; sh_y[0] = '0; sh_w[0] = '0; sh_h[0] = '0;
      sh_rgb[0] = '0; sh_bg[0] = '0;
    end else begin
      edge_cnt++;
      nxt = last_pins;
      nxt.eof = 1'b0;
      if (edge_cnt % 2 == 0) begin
        tick++;
        if (tick % FT == 0 && tick / FT < MAXF) begin
          sh_en[tick/FT]  = layer_en;
          sh_x[tick/FT]   = layer_x;
          sh_y[tick/FT]   = layer_y;
          sh_w[tick/FT]   = layer_w;
          sh_h[tick/FT]   = layer_h;
          sh_rgb[tick/FT] = layer_rgb;
          sh_bg[tick/FT]  = bg_rgb;
        end
        if (tick >= 2) nxt = expect_pixel(tick - 2);
        nxt.eof = is_eof_state(tick - 1);
      end
      last_pins = nxt;
      exp_q.push_back(nxt);
    end
  end

  // Monitor
  initial forever begin
    pins_t act, e;
    @(negedge clk50M);
    act = '{rgb: {red, green, blue}, hs_n: HS, vs_n: VS, eof: endofframe};
    if (!reset) begin
      checks++;
      if (act !== RESET_PINS) begin
        failures++;
        $display("FAIL reset_hold t=%0t actual=%h required=%h", $time, act, RESET_PINS);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL pixel tick=%0d edge=%0d actual rgb=%h hs=%b vs=%b eof=%b required rgb=%h hs=%b vs=%b eof=%b",
                 tick, edge_cnt, act.rgb, act.hs_n, act.vs_n, act.eof, e.rgb, e.hs_n, e.vs_n, e.eof);
      end
    end
  end

  // Wait until the pixel tick is at a given position within a frame.
  task automatic wait_point(input int target);
    bit seen;
    seen = 1'b0;
    repeat (4) @(negedge clk50M);
    for (int c = 0; c < 4 * FT; c++) begin
      @(negedge clk50M);
      if (tick % FT == target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_point actual=timeout required=tick_mod_%0d", target);
    end
  endtask

  task automatic clear_layers();
    layer_en = '0; layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
    layer_rgb = '0; bg_rgb = '0;
  endtask

  task automatic set_layer(input int i, input int x, input int y, input int w, input int h,
                           input logic [7:0] c);
    layer_x[i*CWB +: CWB] = CWB'(x);
    layer_y[i*CWB +: CWB] = CWB'(y);
    layer_w[i*CWB +: CWB] = CWB'(w);
    layer_h[i*CWB +: CWB] = CWB'(h);
    layer_rgb[i*8 +: 8]   = c;
  endtask

  localparam int MID_FRAME = (VSTART + T_VA / 2) * HT + 7;

  initial begin
    pins_t act;
    clear_layers();
    reset = 1'b0;
    repeat (10) @(negedge clk50M);
    reset = 1'b1;

    // Single layer over a non-black background.
    wait_point(MID_FRAME);
    set_layer(0, 3, 2, 8, 4, 8'hE0);
    layer_en = 4'b0001;
    bg_rgb   = 8'h05;

    // Two layers sharing a rectangle: lower index wins.
    wait_point(MID_FRAME);
    set_layer(0, 5, 5, 4, 4, 8'h1C);
    set_layer(2, 5, 5, 4, 4, 8'h03);
    layer_en = 4'b0101;

    // Lower layer disabled: the upper one shows through from the next frame.
    wait_point(MID_FRAME);
    layer_en = 4'b0100;

    // Box crossing the right and bottom edges is clipped, never wrapped.
    wait_point(MID_FRAME);
    clear_layers();
    bg_rgb = 8'h05;
    set_layer(1, 12, 9, 20, 20, 8'hAA);
    layer_en = 4'b0010;

    wait_point(MID_FRAME);
    set_layer(1, 12, 9, 0, 20, 8'hAA);

    // Random configurations, each applied mid-frame at a varying point.
    for (int n = 0; n < 20; n++) begin
      wait_point($urandom_range(1, FT - 2));
      for (int i = 0; i < NL; i++)
        set_layer(i, $urandom_range(0, 20), $urandom_range(0, 15),
                  $urandom_range(0, 10), $urandom_range(0, 8), 8'($urandom));
      layer_en = NL'($urandom);
      bg_rgb   = 8'($urandom);
    end

    // Reset in the middle of the active area.
    wait_point((VSTART + 6) * HT + 8);
    #3;
    reset = 1'b0;
    #1;
    act = '{rgb: {red, green, blue}, hs_n: HS, vs_n: VS, eof: endofframe};
    checks++;
    if (act !== RESET_PINS) begin
      failures++;
      $display("FAIL async_reset actual=%h required=%h", act, RESET_PINS);
    end
    repeat (5) @(negedge clk50M);
    reset = 1'b1;
    set_layer(0, 0, 0, 16, 12, 8'hFF);
    layer_en = 4'b0001;
    bg_rgb   = 8'h55;
    repeat (2 * FT * 2 + 200) @(negedge clk50M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
